pe_load_sequencer: RTL

PE_LOAD_SEQUENCER -- requirements
Module: pe_load_sequencer

---
 rtl/pe_load_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/pe_load_sequencer.sv
// Loads instruction, operand A and operand B words into a PE, then starts it
// and waits for completion, flagging a sticky error if the PE never answers.
module pe_load_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  output logic [31:0] load_data,
  output logic        instr_en,
  output logic        op_a_en,
  output logic        op_b_en,
  output logic        pe_start,
  input  logic        pe_done,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {LD_INSTR, LD_A, LD_B, START, WAIT} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        accept;

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= LD_INSTR;
      wait_cnt    <= 16'd0;
      load_data   <= 32'd0;
      instr_en    <= 1'b0;
      op_a_en     <= 1'b0;
      op_b_en     <= 1'b0;
      pe_start    <= 1'b0;
      busy        <= 1'b0;
      cfg_ready   <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      instr_en <= 1'b0;
      op_a_en  <= 1'b0;
      op_b_en  <= 1'b0;
      pe_start <= 1'b0;
      case (state)
        LD_INSTR: if (accept) begin
          load_data <= cfg_data;
          instr_en  <= 1'b1;
          busy      <= 1'b1;
          state     <= LD_A;
        end
        LD_A: if (accept) begin
          load_data <= cfg_data;
          op_a_en   <= 1'b1;
          state     <= LD_B;
        end
        LD_B: if (accept) begin
          load_data <= cfg_data;
          op_b_en   <= 1'b1;
          cfg_ready <= 1'b0;
          state     <= START;
        end
        // Two cycles here: the first lets operand B settle, the second pulses pe_start.
        START: begin
          if (!pe_start) pe_start <= 1'b1;
          else begin
            wait_cnt <= 16'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // pe_done wins over a simultaneous timeout.
          if (pe_done || wait_cnt == TIMEOUT_CYCLES - 16'd1) begin
            if (!pe_done) timeout_err <= 1'b1;
            wait_cnt  <= 16'd0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= LD_INSTR;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state     <= LD_INSTR;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
